// File: rtl/issue_ctrl.sv
// issue_ctrl: register busy scoreboard, outstanding-write limit, issue/stall
// decision and branch redirect/flush sequencing between decode and execute.
module issue_ctrl #(
    parameter int PC_WIDTH        = 32,
    parameter int RF_ADDR_WIDTH   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dec_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0] dec_rs1_addr_i,
    input  logic                     dec_rs1_used_i,
    input  logic [RF_ADDR_WIDTH-1:0] dec_rs2_addr_i,
    input  logic                     dec_rs2_used_i,
    input  logic [RF_ADDR_WIDTH-1:0] dec_rd_addr_i,
    input  logic                     dec_rd_we_i,
    input  logic                     dec_csr_used_i,
    input  logic                     exu_ready_i,
    input  logic                     wb_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic                     br_valid_i,
    input  logic [PC_WIDTH-1:0]      br_pc_i,
    output logic                     ctrl2dpu_valid_o,
    output logic                     ctrl2dpu_stall_o,
    output logic                     ctrl2dpu_flush_o,
    output logic                     ctrl2pfu_redirect_valid_o,
    output logic [PC_WIDTH-1:0]      ctrl2pfu_redirect_pc_o,
    output logic [3:0]               outstanding_o
);
    localparam int NREG = 2 ** RF_ADDR_WIDTH;
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    logic [0:0]      state;
    logic [2:0]      flush_cnt;
    logic [NREG-1:0] busy, busy_eff, wb_mask, set_mask;
    logic [3:0]      count;
    logic            run, wb_hit, hazard, full, csr_block, fire, inc, dec;
    // A writeback to x0 is ignored entirely, including for the count and full check.
    always_comb begin
        run       = state == RUN;
        wb_hit    = wb_valid_i & (wb_rd_addr_i != '0);
        wb_mask   = wb_hit ? (NREG'(1) << wb_rd_addr_i) : '0;
        busy_eff  = busy & ~wb_mask;
        hazard    = (dec_rs1_used_i & (dec_rs1_addr_i != '0) & busy_eff[dec_rs1_addr_i])
                  | (dec_rs2_used_i & (dec_rs2_addr_i != '0) & busy_eff[dec_rs2_addr_i])
                  | (dec_rd_we_i    & (dec_rd_addr_i  != '0) & busy_eff[dec_rd_addr_i]);
        full      = (count == 4'(MAX_OUTSTANDING)) & ~wb_hit;
        csr_block = dec_csr_used_i & (count != 4'd0);
        fire      = run & dec_valid_i & ~br_valid_i & ~hazard & ~full & ~csr_block & exu_ready_i;
        inc       = fire & dec_rd_we_i & (dec_rd_addr_i != '0);
        dec       = wb_hit & (count != 4'd0);
        set_mask  = inc ? (NREG'(1) << dec_rd_addr_i) : '0;
    end
    assign ctrl2dpu_valid_o = fire;
    assign ctrl2dpu_stall_o = run & dec_valid_i & ~fire & ~br_valid_i;
    assign ctrl2dpu_flush_o = state == FLUSH;
    assign outstanding_o    = count;
    // Set is applied after clear so a same-cycle issue to the retiring register stays busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                     <= RUN;
            flush_cnt                 <= '0;
            busy                      <= '0;
            count                     <= '0;
            ctrl2pfu_redirect_valid_o <= 1'b0;
            ctrl2pfu_redirect_pc_o    <= '0;
        end else begin
            busy                      <= (busy & ~wb_mask) | set_mask;
            count                     <= count + {3'd0, inc} - {3'd0, dec};
            ctrl2pfu_redirect_valid_o <= br_valid_i;
            ctrl2pfu_redirect_pc_o    <= br_valid_i ? br_pc_i : ctrl2pfu_redirect_pc_o;
            state                     <= br_valid_i ? FLUSH
                                       : (state == FLUSH && flush_cnt == 3'd1) ? RUN : state;
            flush_cnt                 <= br_valid_i ? 3'(FLUSH_CYCLES)
                                       : (state == FLUSH) ? flush_cnt - 3'd1 : flush_cnt;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vector table for issue_ctrl plus a flush-length sequence.
module tb_issue_ctrl;
    typedef struct {
        logic        rst, dv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we, csr, rdy, wbv;
        logic [4:0]  wbrd;
        logic        brv;
        logic [31:0] brpc;
        logic        ev, es, ef, er;
        logic [31:0] epc;
        logic [3:0]  eo;
    } vec_t;

    logic        clk = 1'b0, rst;
    logic        dec_valid, rs1_used, rs2_used, rd_we, csr_used, exu_ready, wb_valid, br_valid;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_rd_addr;
    logic [31:0] br_pc, redirect_pc;
    logic        valid, stall, flush, redirect_valid;
    logic [3:0]  outstanding;
    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
        .dec_rs1_addr_i(rs1_addr), .dec_rs1_used_i(rs1_used),
        .dec_rs2_addr_i(rs2_addr), .dec_rs2_used_i(rs2_used),
        .dec_rd_addr_i(rd_addr), .dec_rd_we_i(rd_we), .dec_csr_used_i(csr_used),
        .exu_ready_i(exu_ready), .wb_valid_i(wb_valid), .wb_rd_addr_i(wb_rd_addr),
        .br_valid_i(br_valid), .br_pc_i(br_pc),
        .ctrl2dpu_valid_o(valid), .ctrl2dpu_stall_o(stall), .ctrl2dpu_flush_o(flush),
        .ctrl2pfu_redirect_valid_o(redirect_valid), .ctrl2pfu_redirect_pc_o(redirect_pc),
        .outstanding_o(outstanding)
    );

    function automatic vec_t mk(input int r, dv, rs1, u1, rs2, u2, rd, we, csr, rdy, wbv, wbrd,
                                brv, brpc, ev, es, ef, er, epc, eo);
        vec_t v;
        v.rst = 1'(r); v.dv = 1'(dv); v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2);
        v.u2 = 1'(u2); v.rd = 5'(rd); v.we = 1'(we); v.csr = 1'(csr); v.rdy = 1'(rdy);
        v.wbv = 1'(wbv); v.wbrd = 5'(wbrd); v.brv = 1'(brv); v.brpc = 32'(brpc);
        v.ev = 1'(ev); v.es = 1'(es); v.ef = 1'(ef); v.er = 1'(er); v.epc = 32'(epc); v.eo = 4'(eo);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; dec_valid = v.dv; rs1_addr = v.rs1; rs1_used = v.u1;
        rs2_addr = v.rs2; rs2_used = v.u2; rd_addr = v.rd; rd_we = v.we;
        csr_used = v.csr; exu_ready = v.rdy; wb_valid = v.wbv; wb_rd_addr = v.wbrd;
        br_valid = v.brv; br_pc = v.brpc;
    endtask

    initial begin
        //           rst dv rs1 u1 rs2 u2 rd we csr rdy wbv wbrd brv brpc      ev es ef er epc      eo
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0,       1));
        tbl.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 1, 1, 5, 0, 0,          1, 0, 0, 0, 0,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0,          0, 0, 0, 0, 0,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0,       0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, k, 1, 0, 1, 0, 0, 0, 0,      1, 0, 0, 0, 0,       k-1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0,       4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 1, 1, 1, 0, 0,          1, 0, 0, 0, 0,       4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0,       4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0,          0, 0, 0, 0, 0,       4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0,          0, 0, 0, 0, 0,       3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0,       2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0,          0, 1, 0, 0, 0,       2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0,          0, 1, 0, 0, 0,       1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0,          0, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,          0, 1, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 1, 'h1000,     0, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0,          0, 0, 1, 1, 'h1000,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0,          0, 0, 1, 0, 'h1000,  0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 'h1000,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h3000,     0, 0, 0, 0, 'h1000,  1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h2000,     0, 0, 1, 1, 'h3000,  1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 1, 1, 'h2000,  1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 1, 0, 'h2000,  1));
        tbl.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0,          1, 0, 0, 0, 'h2000,  1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 'h2000,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h4000,     0, 0, 0, 0, 'h2000,  1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,          0, 0, 1, 1, 'h4000,  1));
        tbl.push_back(mk(0, 1, 7, 1, 0, 0,10, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 0, 0,10, 1, 0, 0, 0, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0,       1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,10, 1, 0, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0,       1));
        tbl.push_back(mk(0, 1, 0, 0,10, 0,11, 1, 0, 1, 0, 0, 0, 0,          1, 0, 0, 0, 0,       1));

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk("valid", i, 32'(valid), 32'(tbl[i].ev));
            chk("stall", i, 32'(stall), 32'(tbl[i].es));
            chk("flush", i, 32'(flush), 32'(tbl[i].ef));
            chk("redirect_valid", i, 32'(redirect_valid), 32'(tbl[i].er));
            chk("redirect_pc", i, redirect_pc, tbl[i].epc);
            chk("outstanding", i, 32'(outstanding), 32'(tbl[i].eo));
            @(posedge clk);
            #1;
        end

        // Flush length after a single redirect, bounded wait.
        begin
            int hi = 0, seen_pulse = 0;
            drive(mk(0, 1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 1, 'h5000, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            br_valid = 1'b0;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (flush) hi++;
                if (redirect_valid) begin
                    seen_pulse++;
                    chk("seq_redirect_pc", c, redirect_pc, 32'h5000);
                end
                if (flush) chk("seq_valid_in_flush", c, 32'(valid), 32'd0);
                @(posedge clk);
                #1;
            end
            chk("seq_flush_cycles", 0, 32'(hi), 32'd2);
            chk("seq_pulse_count", 0, 32'(seen_pulse), 32'd1);
            chk("seq_outstanding", 0, 32'(outstanding), 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Central issue/hazard controller sitting between the DPU decode stage and the execute stage.
- Keeps a register-file busy scoreboard and an outstanding-write counter, and decides each cycle whether the decoded instruction issues or stalls.
- Sequences branch redirects: PFU redirect pulse plus a timed flush of the DPU.
- Its flush/stall/valid outputs drive the DPU ctrl2dpu_* inputs.

Parameters:
- PC_WIDTH, 32, width of the program counter.
- RF_ADDR_WIDTH, 5, register-file address width (2**RF_ADDR_WIDTH entries; entry 0 is hardwired zero).
- MAX_OUTSTANDING, 4, maximum in-flight register-writing instructions (range 1..15).
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (range 1..7).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous active-high
- dec_valid_i  in  1  DPU holds a decoded instruction
- dec_rs1_addr_i  in  RF_ADDR_WIDTH  source 1 address
- dec_rs1_used_i  in  1  source 1 read by the instruction
- dec_rs2_addr_i  in  RF_ADDR_WIDTH  source 2 address
- dec_rs2_used_i  in  1  source 2 read by the instruction
- dec_rd_addr_i  in  RF_ADDR_WIDTH  destination address
- dec_rd_we_i  in  1  instruction writes rd
- dec_csr_used_i  in  1  CSR instruction (serializing)
- exu_ready_i  in  1  execute stage can accept an instruction
- wb_valid_i  in  1  writeback retires a register write
- wb_rd_addr_i  in  RF_ADDR_WIDTH  retired destination
- br_valid_i  in  1  DPU resolved a taken branch/jump (dpu2ctrl_valid_o)
- br_pc_i  in  PC_WIDTH  redirect target (dpu2ctrl_branch_pc_o)
- ctrl2dpu_valid_o  out  1  instruction issues this cycle
- ctrl2dpu_stall_o  out  1  DPU must hold its instruction
- ctrl2dpu_flush_o  out  1  DPU must discard its instruction
- ctrl2pfu_redirect_valid_o  out  1  one-cycle redirect pulse to the PFU
- ctrl2pfu_redirect_pc_o  out  PC_WIDTH  redirect target
- outstanding_o  out  4  current outstanding-write count

Behaviour:
- Reset (rst_i high at a clock edge):
  - All busy bits cleared, count = 0, state = RUN.
  - All outputs 0, redirect pc = 0.
  - Reset mid-flush aborts the flush immediately.
- States:
  - RUN: issue permitted.
  - FLUSH: flush counter active; issue blocked.
- Effective busy: busy_eff[r] = busy[r] & ~(wb_valid_i & wb_rd_addr_i==r). Same-cycle writeback is visible to the hazard check.
- Hazard is the OR of:
  - rs1_used & rs1!=0 & busy_eff[rs1]
  - rs2_used & rs2!=0 & busy_eff[rs2]
  - rd_we & rd!=0 & busy_eff[rd] (WAW)
- full = (count == MAX_OUTSTANDING) & ~wb_valid_i.
- csr_block = dec_csr_used_i & (count != 0): CSR instructions wait until all writes have drained.
- fire = RUN & dec_valid_i & ~br_valid_i & ~hazard & ~full & ~csr_block & exu_ready_i.
- Output equations (combinational, zero-cycle latency):
  - ctrl2dpu_valid_o = fire.
  - ctrl2dpu_stall_o = RUN & dec_valid_i & ~fire & ~br_valid_i.
- On fire with rd_we & rd!=0:
  - busy[rd] set next cycle.
  - count +1.
- On wb_valid_i:
  - Clears busy[wb_rd_addr_i]; a wb to a non-busy register has no effect on busy.
  - count -1 only if count != 0 (no underflow).
  - A wb to register 0 is ignored entirely.
- Same cycle issue-set and wb-clear of the same register: set wins. Count is net unchanged when both inc and dec apply.
- Register 0 is never marked busy.
- Branch redirect:
  - br_valid_i in any state means: next cycle ctrl2pfu_redirect_valid_o = 1 for exactly one cycle, ctrl2pfu_redirect_pc_o = br_pc_i (held until the next redirect).
  - State goes to FLUSH with flush counter = FLUSH_CYCLES.
  - ctrl2dpu_flush_o = 1 while in FLUSH; the counter decrements each cycle and the state returns to RUN when it reaches 1.
  - Flush is therefore high exactly FLUSH_CYCLES cycles.
  - br_valid_i during FLUSH reloads the counter and produces a new redirect pulse with the new pc.
  - Busy bits and count are untouched by redirect; older instructions still retire.
- In FLUSH: valid_o = 0 and stall_o = 0 regardless of dec_valid_i.

Test Plan:
- Reset, then issue rd=5 (we=1), then the next instruction with rs1=5 and no wb → stall_o=1, valid_o=0. Then wb_rd_addr=5 → valid_o=1 in that same cycle.
- Issue 4 writes to x1..x4 with no wb → count=4; a 5th independent write stalls. A wb in the same cycle as the 5th write → 5th issues, count remains 4.
- br_valid_i=1, br_pc_i=0x0000_1000 with FLUSH_CYCLES=2 → redirect pulse with pc 0x1000 next cycle, flush_o high 2 cycles, valid_o=0 throughout. A second br at flush cycle 1 with pc 0x2000 → new pulse and flush extended to 2 more cycles.
- CSR instruction while count=2 → stalls until two wbs bring count to 0, then issues with valid_o=1.
- rs1=0 with rd=0 writes issued repeatedly → never stall, count stays 0. A wb with count=0 → count stays 0.
- Assert rst_i during FLUSH with x7 busy → next cycle flush_o=0, x7 not busy (rs1=7 issues), count=0.
